npc_core_ctrl: RTL
==================

Name: npc_core_ctrl

Overview:
- Multi-cycle control FSM for the single-issue RV64 NPC core.
- Fetches instructions over a valid handshake and presents each one to the instruction decoder.
- Reads the decoder's opcode, immediate and register fields, then performs writeback and next-PC selection for ADDI, LUI, AUIPC, JAL and JALR.
- Halts on EBREAK, illegal opcode or misaligned jump target; owns the architectural PC and the retired-instruction counter.

Parameters:
- RESET_PC, 64'h8000_0000, PC value loaded on reset.
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high throughout FETCH.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_rvalid  in  1  instruction-memory response valid.
- imem_rdata  in  32  instruction word; sampled when imem_rvalid=1 in FETCH.
- inst  out  32  latched instruction, driven to the decoder.
- dec_opcode  in  7  decoder opcode field.
- dec_imm  in  XLEN  decoder sign-extended immediate.
- dec_rs1  in  5  decoder source register index.
- dec_rd  in  5  decoder destination register index.
- rf_raddr  out  5  register-file read index; equals dec_rs1.
- rf_rdata  in  XLEN  combinational register-file read data.
- rf_we  out  1  register-file write enable; one-cycle pulse.
- rf_waddr  out  5  write index.
- rf_wdata  out  XLEN  write data.
- pc  out  XLEN  architectural PC.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  64  retired-instruction count.
- halted  out  1  sticky halt flag.
- halt_code  out  2  halt cause: 0=EBREAK, 1=illegal opcode, 2=misaligned target; valid while halted=1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC; inst=0; imem_req=0; rf_we=0; rf_waddr=0; rf_wdata=0; retire=0; instret=0; halted=0; halt_code=0.
  - State goes to FETCH. rst takes priority over every other event, including rst asserted mid-fetch or while HALT.
- States: FETCH -> DECODE -> EXEC -> FETCH; HALT is terminal and is left only by reset.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - When imem_rvalid=1: latch inst=imem_rdata, drop imem_req on the next cycle, go to DECODE.
  - Otherwise stay in FETCH with imem_req held; there is no timeout.
  - imem_rvalid in any other state is ignored.
  - The instruction memory must be reset by the same rst, so no stale response arrives after reset.
- DECODE: one cycle with no outputs changing. Decoder and register-file read settle.
- EXEC: one cycle. Using rs1v=rf_rdata and imm=dec_imm (all arithmetic modulo 2^64):
  - ADDI (0010011): wdata=rs1v+imm, npc=pc+4.
  - LUI (0110111): wdata=imm, npc=pc+4.
  - AUIPC (0010111): wdata=pc+imm, npc=pc+4.
  - JAL (1101111): wdata=pc+4, npc=pc+imm.
  - JALR (1100111): wdata=pc+4, npc=(rs1v+imm) with bit0 cleared.
  - inst==32'h0010_0073: go to HALT, halt_code=0.
  - Any other opcode, including other SYSTEM encodings: go to HALT, halt_code=1.
  - npc[1]==1 on JAL or JALR: go to HALT, halt_code=2.
  - On any halt: no register write, no retire, pc unchanged (it points at the faulting instruction), instret unchanged.
  - Normal completion, registered at the EXEC edge and visible in the following cycle:
    - rf_we=1 for exactly one cycle, with rf_waddr=dec_rd and rf_wdata=wdata.
    - rf_we is suppressed when dec_rd==0; waddr and wdata may still update.
    - pc=npc; retire=1 for one cycle; instret+1 (wraps to 0 after all-ones).
    - Next state is FETCH, so imem_req=1 in the same cycle as the rf_we pulse.
- Throughput: minimum 3 cycles per instruction (rvalid in the first FETCH cycle), plus one cycle per cycle of memory wait.
- HALT: halted=1 (sticky); imem_req=0, rf_we=0, retire=0; all other outputs hold.

Test Plan:
- Reset, then rvalid on the first FETCH cycle with 0x00500093 (addi x1,x0,5) -> imem_addr=0x80000000; rf_we pulse x1=5 three cycles after the first req; pc=0x80000004; instret=1.
- rvalid delayed 4 cycles -> imem_req stays high 5 cycles, inst is latched only on the rvalid cycle, total 7 cycles to retire; rvalid pulses injected during DECODE/EXEC are ignored.
- 0x12345037 (lui x0) -> no rf_we, pc+4, retire=1. AUIPC at 0x80000004 with imm 0x1000 -> wdata=0x80001004.
- JAL x1,+16 at 0x80000008 -> x1=0x8000000C, pc=0x80000018. JALR with rs1v=0x80000003, imm=0 -> pc=0x80000002, which has bit1 set -> halt_code=2, no write, pc unchanged.
- EBREAK -> halted=1, halt_code=0, imem_req=0 thereafter. Opcode 0x33 -> halt_code=1.
- rst asserted mid-FETCH and again in HALT -> next cycle pc=0x80000000, halted=0, instret=0, imem_req=1.

Source files
------------

// File: rtl/npc_core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC control for the RV64 NPC core.
// Executes ADDI/LUI/AUIPC/JAL/JALR, halts on EBREAK, illegal opcode or misaligned target.
module npc_core_ctrl #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  input  logic [6:0]      dec_opcode,
  input  logic [XLEN-1:0] dec_imm,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rd,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic [63:0]     instret,
  output logic            halted,
  output logic [1:0]      halt_code
);

  localparam logic [6:0]  OP_ADDI  = 7'b0010011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] wdata, npc, jsum;
  logic            exec_ok;
  logic [1:0]      hcode;

  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;
  assign rf_raddr  = dec_rs1;
  assign jsum      = rf_rdata + dec_imm;

  // EBREAK is matched on the full word before the opcode, since its opcode is otherwise illegal
  always_comb begin
    wdata   = '0;
    npc     = pc + XLEN'(4);
    exec_ok = 1'b1;
    hcode   = 2'd0;
    if (inst == EBREAK) begin
      exec_ok = 1'b0;
      hcode   = 2'd0;
    end else begin
      case (dec_opcode)
        OP_ADDI:  wdata = jsum;
        OP_LUI:   wdata = dec_imm;
        OP_AUIPC: wdata = pc + dec_imm;
        OP_JAL: begin
          wdata = pc + XLEN'(4);
          npc   = pc + dec_imm;
        end
        OP_JALR: begin
          wdata = pc + XLEN'(4);
          npc   = {jsum[XLEN-1:1], 1'b0};
        end
        default: begin
          exec_ok = 1'b0;
          hcode   = 2'd1;
        end
      endcase
      if (exec_ok && (dec_opcode == OP_JAL || dec_opcode == OP_JALR) && npc[1]) begin
        exec_ok = 1'b0;
        hcode   = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (imem_rvalid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = exec_ok ? S_FETCH : S_HALT;
      default:  state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      retire    <= 1'b0;
      instret   <= '0;
      halted    <= 1'b0;
      halt_code <= '0;
    end else begin
      rf_we  <= 1'b0;
      retire <= 1'b0;
      if (state == S_FETCH && imem_rvalid) inst <= imem_rdata;
      if (state == S_EXEC) begin
        if (exec_ok) begin
          rf_we    <= (dec_rd != 5'd0);
          rf_waddr <= dec_rd;
          rf_wdata <= wdata;
          pc       <= npc;
          retire   <= 1'b1;
          instret  <= instret + 64'd1;
        end else begin
          halted    <= 1'b1;
          halt_code <= hcode;
        end
      end
    end
  end

endmodule
